// File: rtl/clipper_timebase_gen.sv
// -----------------------------------------------------------------------------
// clipper_timebase_gen
//
// Device-wide 64-bit timebase generator. Two counters are kept:
//   - a controlled timebase that honours force-load, freeze and accelerate
//     requests from the control side, and
//   - a free-running timebase that ignores all control.
// Both use the format [63:32] = seconds, [31:0] = nanoseconds, with the
// nanosecond field wrapping at NS_WRAP and carrying into seconds.
//
// Parameters:
//   INC_NS      nanoseconds added per clock in normal mode (1..255)
//   ACCEL_SHIFT accelerated increment is INC_NS << ACCEL_SHIFT (0..16)
//   NS_WRAP     nanosecond field wrap value
//
// Ports:
//   clk                  in   1   timebase clock
//   rst_n                in   1   asynchronous active-low reset
//   timebase_force       in   1   level request to load timebase_time
//   timebase_accelerate  in   1   level, selects the accelerated increment
//   timebase_time        in  64   value to load
//   freeze               in   1   level, holds the controlled timebase
//   force_ack            out  1   one-cycle pulse acknowledging a force
//   force_err            out  1   one-cycle pulse with force_ack on rejection
//   timebase             out 64   controlled timebase
//   free_run_timebase    out 64   uncontrolled timebase
//   pps                  out  1   one-cycle pulse when controlled seconds carry
// -----------------------------------------------------------------------------
module clipper_timebase_gen #(
    parameter int unsigned INC_NS      = 8,
    parameter int unsigned ACCEL_SHIFT = 10,
    parameter int unsigned NS_WRAP     = 1000000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timebase_force,
    input  logic        timebase_accelerate,
    input  logic [63:0] timebase_time,
    input  logic        freeze,
    output logic        force_ack,
    output logic        force_err,
    output logic [63:0] timebase,
    output logic [63:0] free_run_timebase,
    output logic        pps
);

    localparam logic [31:0] NS_WRAP_W = 32'(NS_WRAP);
    localparam logic [31:0] INC_NORM  = 32'(INC_NS);
    localparam logic [31:0] INC_ACCEL = 32'(INC_NS) << ACCEL_SHIFT;

    // Per-cycle action applied to the controlled timebase, in priority order.
    typedef enum logic [1:0] {
        MODE_LOAD  = 2'd0,
        MODE_HOLD  = 2'd1,
        MODE_ACCEL = 2'd2,
        MODE_NORM  = 2'd3
    } mode_e;

    // True when adding inc to the ns field reaches or passes the wrap value.
    // The sum is formed in 33 bits so a large ns plus inc cannot overflow.
    function automatic logic ns_wraps(input logic [31:0] ns, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, ns} + {1'b0, inc};
        return (sum >= {1'b0, NS_WRAP_W});
    endfunction

    // Advances a {sec, ns} value by inc. inc is always below NS_WRAP so at
    // most one carry into seconds can occur; seconds wrap modulo 2^32.
    function automatic logic [63:0] tb_step(input logic [63:0] t, input logic [31:0] inc);
        logic [32:0] sum;
        logic [32:0] rem;
        sum = {1'b0, t[31:0]} + {1'b0, inc};
        rem = sum - {1'b0, NS_WRAP_W};
        if (sum >= {1'b0, NS_WRAP_W}) begin
            return {t[63:32] + 32'd1, rem[31:0]};
        end else begin
            return {t[63:32], sum[31:0]};
        end
    endfunction

    logic        force_prev_r;
    logic [63:0] timebase_r;
    logic [63:0] free_run_r;
    logic        force_ack_r;
    logic        force_err_r;
    logic        pps_r;

    logic        force_edge_s;
    logic        force_ok_s;
    mode_e       mode_s;
    logic [63:0] timebase_next_s;
    logic        pps_next_s;
    logic [63:0] free_run_next_s;

    assign force_edge_s    = timebase_force & ~force_prev_r;
    assign force_ok_s      = (timebase_time[31:0] < NS_WRAP_W);
    assign free_run_next_s = tb_step(free_run_r, INC_NORM);

    // Select this cycle's action. A rejected force edge falls through to the
    // lower-priority rules, so it only counts as a load when the ns is legal.
    always_comb begin
        mode_s = MODE_NORM;
        if (force_edge_s && force_ok_s) begin
            mode_s = MODE_LOAD;
        end else if (freeze) begin
            mode_s = MODE_HOLD;
        end else if (timebase_accelerate) begin
            mode_s = MODE_ACCEL;
        end else begin
            mode_s = MODE_NORM;
        end
    end

    // Next controlled timebase and pps. pps only reflects a counting carry:
    // a load that changes seconds does not pulse it, and hold never does.
    always_comb begin
        timebase_next_s = timebase_r;
        pps_next_s      = 1'b0;
        case (mode_s)
            MODE_LOAD: begin
                timebase_next_s = timebase_time;
            end
            MODE_HOLD: begin
                timebase_next_s = timebase_r;
            end
            MODE_ACCEL: begin
                timebase_next_s = tb_step(timebase_r, INC_ACCEL);
                pps_next_s      = ns_wraps(timebase_r[31:0], INC_ACCEL);
            end
            MODE_NORM: begin
                timebase_next_s = tb_step(timebase_r, INC_NORM);
                pps_next_s      = ns_wraps(timebase_r[31:0], INC_NORM);
            end
            default: begin
                timebase_next_s = timebase_r;
                pps_next_s      = 1'b0;
            end
        endcase
    end

    // State registers. Clearing force_prev_r on reset makes a force held high
    // through reset release look like a fresh request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_prev_r <= 1'b0;
            timebase_r   <= 64'd0;
            free_run_r   <= 64'd0;
            force_ack_r  <= 1'b0;
            force_err_r  <= 1'b0;
            pps_r        <= 1'b0;
        end else begin
            force_prev_r <= timebase_force;
            timebase_r   <= timebase_next_s;
            free_run_r   <= free_run_next_s;
            force_ack_r  <= force_edge_s;
            force_err_r  <= force_edge_s & ~force_ok_s;
            pps_r        <= pps_next_s;
        end
    end

    assign timebase          = timebase_r;
    assign free_run_timebase = free_run_r;
    assign force_ack         = force_ack_r;
    assign force_err         = force_err_r;
    assign pps               = pps_r;

endmodule

// File: tb/tb_clipper_timebase_gen.sv
module tb_clipper_timebase_gen;

    logic        clk;
    logic        rst_n;
    logic        timebase_force;
    logic        timebase_accelerate;
    logic [63:0] timebase_time;
    logic        freeze;
    logic        force_ack;
    logic        force_err;
    logic [63:0] timebase;
    logic [63:0] free_run_timebase;
    logic        pps;

    clipper_timebase_gen #(
        .INC_NS      (8),
        .ACCEL_SHIFT (10),
        .NS_WRAP     (1000000000)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .timebase_force      (timebase_force),
        .timebase_accelerate (timebase_accelerate),
        .timebase_time       (timebase_time),
        .freeze              (freeze),
        .force_ack           (force_ack),
        .force_err           (force_err),
        .timebase            (timebase),
        .free_run_timebase   (free_run_timebase),
        .pps                 (pps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index: number of rising edges since the last reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          due;
        string       name;
        logic [63:0] tb;
        bit          chk_fr;
        logic [63:0] fr;
    } snap_t;

    typedef struct {
        int due;
        bit err;
    } ack_t;

    snap_t snap_q[$];
    ack_t  ack_q[$];
    int    pps_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_tb(input int due, input string nm, input logic [63:0] tb,
                             input bit cf, input logic [63:0] fr);
        snap_t s;
        s.due = due; s.name = nm; s.tb = tb; s.chk_fr = cf; s.fr = fr;
        snap_q.push_back(s);
    endtask

    task automatic expect_ack(input int due, input bit err);
        ack_t a;
        a.due = due; a.err = err;
        ack_q.push_back(a);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: pops expectations as the DUT presents snapshots, acks and pps.
    always @(negedge clk) begin
        if (rst_n) begin
            while (snap_q.size() > 0 && snap_q[0].due <= cyc) begin
                snap_t s;
                s = snap_q.pop_front();
                if (s.due < cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s: snapshot missed, now cycle %0d want cycle %0d", s.name, cyc, s.due);
                end else begin
                    chk64({s.name, ".timebase"}, timebase, s.tb);
                    if (s.chk_fr) chk64({s.name, ".free_run"}, free_run_timebase, s.fr);
                end
            end
            while (ack_q.size() > 0 && ack_q[0].due < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL force_ack: got 0 expected 1 at cycle %0d", ack_q[0].due);
                void'(ack_q.pop_front());
            end
            if (force_ack) begin
                if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
                    ack_t a;
                    a = ack_q.pop_front();
                    chk64("force_ack", 64'(force_ack), 64'd1);
                    chk64("force_err", 64'(force_err), 64'(a.err));
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL force_ack: got 1 expected 0 at cycle %0d", cyc);
                end
            end else if (force_err) begin
                n_cmp++; n_bad++;
                $display("FAIL force_err: got 1 without force_ack at cycle %0d", cyc);
            end
            while (pps_q.size() > 0 && pps_q[0] < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL pps: got 0 expected 1 at cycle %0d", pps_q[0]);
                void'(pps_q.pop_front());
            end
            if (pps) begin
                if (pps_q.size() > 0 && pps_q[0] == cyc) begin
                    void'(pps_q.pop_front());
                    chk64("pps", 64'(pps), 64'd1);
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL pps: got 1 expected 0 at cycle %0d", cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        timebase_force = 1'b0;
        timebase_accelerate = 1'b0;
        timebase_time = 64'd0;
        freeze = 1'b0;
        repeat (3) @(negedge clk);
        chk64("reset.timebase", timebase, 64'd0);
        chk64("reset.free_run", free_run_timebase, 64'd0);
        chk64("reset.flags", {61'd0, force_ack, force_err, pps}, 64'd0);

        // free counting from reset
        expect_tb(1,  "count1",  64'h0000_0000_0000_0008, 1'b1, 64'h0000_0000_0000_0008);
        expect_tb(10, "count10", 64'h0000_0000_0000_0050, 1'b1, 64'h0000_0000_0000_0050);
        rst_n = 1'b1;
        wait_cyc(10);

        // preload near a second boundary, then one normal cycle carries
        timebase_time  = 64'h0000_0005_3B9A_C9F8;
        timebase_force = 1'b1;
        expect_tb(11, "preload", 64'h0000_0005_3B9A_C9F8, 1'b1, 64'h0000_0000_0000_0058);
        expect_ack(11, 1'b0);
        expect_tb(12, "carry",   64'h0000_0006_0000_0000, 1'b1, 64'h0000_0000_0000_0060);
        pps_q.push_back(12);
        wait_cyc(12);
        timebase_force = 1'b0;

        // accepted force, then held high for 20 cycles without re-ack
        wait_cyc(13);
        timebase_time  = 64'h0000_0010_0000_0064;
        timebase_force = 1'b1;
        expect_ack(14, 1'b0);
        expect_tb(14, "force",     64'h0000_0010_0000_0064, 1'b0, 64'd0);
        expect_tb(34, "forcehold", 64'h0000_0010_0000_0104, 1'b1, 64'h0000_0000_0000_0110);
        wait_cyc(34);
        timebase_force = 1'b0;

        // rejected force: ns equal to wrap value
        wait_cyc(35);
        timebase_time  = 64'h0000_0020_3B9A_CA00;
        timebase_force = 1'b1;
        expect_ack(36, 1'b1);
        expect_tb(36, "reject",    64'h0000_0010_0000_0114, 1'b0, 64'd0);
        expect_tb(37, "rejectnxt", 64'h0000_0010_0000_011C, 1'b1, 64'h0000_0000_0000_0128);
        wait_cyc(36);
        timebase_force = 1'b0;

        // freeze with accelerate for 100 cycles, then accelerated counting
        wait_cyc(37);
        freeze = 1'b1;
        timebase_accelerate = 1'b1;
        expect_tb(137, "frozen", 64'h0000_0010_0000_011C, 1'b1, 64'h0000_0000_0000_0448);
        expect_tb(138, "accel1", 64'h0000_0010_0000_211C, 1'b0, 64'd0);
        expect_tb(139, "accel2", 64'h0000_0010_0000_411C, 1'b0, 64'd0);
        wait_cyc(137);
        freeze = 1'b0;
        wait_cyc(139);

        // accelerated carry at the seconds wrap boundary
        timebase_time  = 64'hFFFF_FFFF_3B9A_C000;
        timebase_force = 1'b1;
        expect_ack(140, 1'b0);
        expect_tb(140, "secmax",  64'hFFFF_FFFF_3B9A_C000, 1'b0, 64'd0);
        expect_tb(141, "secwrap", 64'h0000_0000_0000_1600, 1'b0, 64'd0);
        pps_q.push_back(141);
        expect_tb(142, "normal",  64'h0000_0000_0000_1608, 1'b0, 64'd0);
        wait_cyc(140);
        timebase_force = 1'b0;
        wait_cyc(141);
        timebase_accelerate = 1'b0;

        // force during freeze: loaded then held, no pps while frozen
        wait_cyc(142);
        freeze = 1'b1;
        timebase_time  = 64'h0000_0042_3B9A_C9FF;
        timebase_force = 1'b1;
        expect_ack(143, 1'b0);
        expect_tb(143, "frzload", 64'h0000_0042_3B9A_C9FF, 1'b0, 64'd0);
        expect_tb(150, "frzhold", 64'h0000_0042_3B9A_C9FF, 1'b0, 64'd0);
        expect_tb(151, "unfrz",   64'h0000_0043_0000_0007, 1'b1, 64'h0000_0000_0000_04B8);
        pps_q.push_back(151);
        wait_cyc(150);
        freeze = 1'b0;
        timebase_force = 1'b0;

        // mid-count reset with a pending force
        wait_cyc(152);
        timebase_time  = 64'h0000_0007_0000_0000;
        timebase_force = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk64("midrst.timebase", timebase, 64'd0);
        chk64("midrst.free_run", free_run_timebase, 64'd0);
        chk64("midrst.force_ack", 64'(force_ack), 64'd0);
        chk64("midrst.force_err", 64'(force_err), 64'd0);
        chk64("midrst.pps", 64'(pps), 64'd0);

        // force held through reset release counts as a new edge
        repeat (2) @(negedge clk);
        expect_ack(1, 1'b0);
        expect_tb(1, "relload", 64'h0000_0007_0000_0000, 1'b1, 64'h0000_0000_0000_0008);
        rst_n = 1'b1;
        wait_cyc(3);
        timebase_force = 1'b0;

        chk64("pending.snap", 64'(snap_q.size()), 64'd0);
        chk64("pending.ack",  64'(ack_q.size()),  64'd0);
        chk64("pending.pps",  64'(pps_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
